// File: rtl/mem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_responder
// Description : Wait-state memory responder for a multi-cycle MIPS datapath.
//               Serves MemRead/MemWrite requests against a unified
//               instruction/data word array. Each accepted request completes
//               LATENCY cycles later with a one-cycle MemReady pulse; Busy
//               is high while the request is pending so the controller can
//               stall.
// Ports       : clk       - system clock, rising-edge
//               rst       - synchronous reset, active-high
//               MemRead   - read request, sampled only in IDLE
//               MemWrite  - write request, sampled only in IDLE (wins over read)
//               Adr       - byte address, word index = Adr[DEPTH_LOG2+1:2]
//               WriteData - store data, captured with the request
//               ReadData  - registered read data, updated on read completion
//               MemReady  - one-cycle completion pulse
//               Busy      - high while a request is pending (WAIT)
//               MemErr    - (MEM_MISALIGN_TRAP_EN only) misaligned-access
//                           pulse, coincident with MemReady
// Options     : `define MEM_MISALIGN_TRAP_EN to trap accesses with
//               Adr[1:0] != 0 instead of silently aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        MemErr,
`endif
    output logic        Busy
);

    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              count;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [31:0]             req_wdata;
    logic                    req_write;
    logic                    req_misalign;

    logic [31:0]             mem [0:DEPTH-1];

    // The edge that leaves WAIT is the edge that enters DONE; both the array
    // write and the read-data capture happen on that edge.
    logic                    finishing;
    logic                    do_write;

    assign finishing = (state == ST_WAIT) && (count == 4'd0);
    assign do_write  = finishing && req_write && !req_misalign;
    assign Busy      = (state == ST_WAIT);

    // Address bits outside the word index carry no meaning here.
    logic unused_adr;
    assign unused_adr = ^{Adr[31:DEPTH_LOG2+2], Adr[1:0]};

    // Array is never cleared; a reset coinciding with the would-be DONE
    // entry edge aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[req_idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= 4'd0;
            ReadData  <= 32'd0;
            MemReady  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            MemErr    <= 1'b0;
`endif
        end else begin
            MemReady <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            MemErr   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (MemRead || MemWrite) begin
                        req_idx   <= Adr[DEPTH_LOG2+1:2];
                        req_wdata <= WriteData;
                        req_write <= MemWrite;
                        count     <= COUNT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count == 4'd0) begin
                        state    <= ST_DONE;
                        MemReady <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                        MemErr   <= req_misalign;
`endif
                        if (!req_write && !req_misalign) begin
                            ReadData <= mem[req_idx];
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE && (MemRead || MemWrite)) begin
            req_misalign <= (Adr[1:0] != 2'b00);
        end
    end
`else
    assign req_misalign = 1'b0;
`endif

endmodule
`default_nettype wire
